histogram_sram_hakem: RTL and testbench
=======================================

// Module: histogram_sram_hakem
// PURPOSE
//  Owns the single 2^PIXEL_BIT x VERI_BIT histogram SRAM (1 write + 1 read port) and shares it between
//  three requesters: 0=histogram builder (HB), 1=equaliser write-back (HE), 2=pixel readout (OKU).
//  Grants whole-burst ownership round-robin and replays the SRAM command during stall.
//  Also sequences the frame-start clear sweep that zeroes every SRAM bin.
// PARAMETERS
//  PIXEL_BIT  8   SRAM address width; bin count = 2^PIXEL_BIT
//  VERI_BIT   17  SRAM data width (bin count / CDF value)
// PORTS
//  clk_i            in   1             single clock, all logic on posedge
//  rstn_i           in   1             asynchronous active-low reset
//  stal_i           in   1             global stall; freezes all state
//  temizle_i        in   1             1-cycle pulse: request clear sweep
//  temizle_bitti_o  out  1             1-cycle pulse: clear sweep finished
//  istek_i          in   3             per-requester ownership request; held for the whole burst
//  izin_o           out  3             one-hot grant, registered
//  wr_en_i          in   3             per-requester write enable, active-high
//  addr_w_i         in   3*PIXEL_BIT   write address, slice k = [k*PIXEL_BIT +: PIXEL_BIT]
//  data_w_i         in   3*VERI_BIT    write data, slice k = [k*VERI_BIT +: VERI_BIT]
//  rd_en_i          in   3             per-requester read enable, active-high
//  addr_r_i         in   3*PIXEL_BIT   read address, packed as addr_w_i
//  rd_data_o        out  VERI_BIT      read data, shared bus (= sram_rd_data_i)
//  rd_gecerli_o     out  3             one-hot: rd_data_o valid for requester k
//  sram_wr_en_n_o   out  1             SRAM write enable, active-low
//  sram_addr_w_o    out  PIXEL_BIT     SRAM write address
//  sram_data_w_o    out  VERI_BIT      SRAM write data
//  sram_rd_en_n_o   out  1             SRAM read enable, active-low
//  sram_addr_r_o    out  PIXEL_BIT     SRAM read address
//  sram_rd_data_i   in   VERI_BIT      SRAM read data, 1 cycle after a read command
// BEHAVIOUR
//  Reset values: izin_o=0, rd_gecerli_o=0, temizle_bitti_o=0, sram_*_en_n_o=1, addresses/data=0.
//  Reset internals: FSM=BOSTA, son_sahip=2 (HB wins first), clear-pending=0, clear counter=0.
//  Reset asserted mid-burst or mid-sweep aborts immediately; no temizle_bitti_o pulse is emitted.
//  FSM states:
//   BOSTA: clear-pending -> TEMIZLE (counter=0); clear has priority over requests.
//          Else any istek_i -> pick first set bit scanning son_sahip+1, +2, +3 (mod 3).
//          Then izin_o=onehot(k), son_sahip=k, FSM=SAHIP next cycle.
//          No SRAM command issued in BOSTA.
//   SAHIP: owner k's wr/rd enables, addresses and data drive the SRAM the same cycle (mux on izin_o).
//          Other requesters' commands are ignored.
//          istek_i[k]=0 at t -> izin_o=0 and FSM=BOSTA at t+1; the owner's command at t is still
//          forwarded. Earliest next grant at t+2.
//   TEMIZLE: each non-stalled cycle write addr=counter, data=0; no reads issued; counter++.
//          Last address (all ones) written at t -> temizle_bitti_o=1 at t+1 only, FSM=BOSTA at t+1.
//  temizle_i in any state except TEMIZLE sets clear-pending; it is served at the next BOSTA.
//  temizle_i during TEMIZLE is ignored.
//  Grant latency: istek in BOSTA at t -> izin_o at t+1.
//  Read return: non-stalled read at t -> rd_gecerli_o=onehot(issuer) at t+1, rd_data_o=sram_rd_data_i.
//  rd_gecerli_o is one-hot or zero.
//  Read and write to the same address in the same cycle: passed through unchanged;
//  SRAM is read-first (old data returned).
//  stal_i=1: FSM, counters, izin_o, rd_gecerli_o and pending flag frozen.
//   sram_* outputs equal the last non-stalled cycle's command (replay; write repeat is idempotent).
//   temizle_i and istek_i changes are not sampled.
//  Width rules: no arithmetic on data; clear counter is PIXEL_BIT wide, end detected at all-ones.
// TESTING
//  T1 reset, temizle_i pulse -> clear sweep with sram_wr_en_n_o=0 for 256 cycles, addr 0..255,
//     data 0, then temizle_bitti_o=1 for 1 cycle and FSM idle.
//  T2 istek_i=3'b011 at t from reset -> izin_o=3'b001 at t+1; HB drops istek at t+5 -> izin_o=0 at t+6,
//     izin_o=3'b010 at t+7.
//  T3 istek_i=3'b111 held, each owner releases after 4 cycles -> grant order 001,010,100,001.
//  T4 HB owner writes addr 0x20 data 7; HE drives wr_en addr 0x10 same cycle
//     -> SRAM sees only the 0x20 write.
//  T5 OKU owner reads addr 5 (mem=0x1ABCD), stal_i=1 next 3 cycles -> rd_gecerli_o=3'b100 and
//     rd_data_o=0x1ABCD held through stall; sram_addr_r_o stays 5.
//  T6 temizle_i during HB ownership with HE requesting -> after HB release, full 256-cycle sweep
//     then izin_o=3'b010.

Source files
------------

// File: rtl/histogram_sram_hakem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : histogram_sram_hakem                                            |
// | Purpose  : Round-robin burst arbiter for the histogram SRAM shared by the  |
// |            histogram builder, equaliser write-back and pixel readout, plus |
// |            the frame-start clear sweep. Replays the SRAM command on stall. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module histogram_sram_hakem #(
   parameter int PIXEL_BIT = 8,
   parameter int VERI_BIT  = 17
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     stal_i,
   input  logic                     temizle_i,
   output logic                     temizle_bitti_o,
   input  logic [2:0]               istek_i,
   output logic [2:0]               izin_o,
   input  logic [2:0]               wr_en_i,
   input  logic [3*PIXEL_BIT-1:0]   addr_w_i,
   input  logic [3*VERI_BIT-1:0]    data_w_i,
   input  logic [2:0]               rd_en_i,
   input  logic [3*PIXEL_BIT-1:0]   addr_r_i,
   output logic [VERI_BIT-1:0]      rd_data_o,
   output logic [2:0]               rd_gecerli_o,
   output logic                     sram_wr_en_n_o,
   output logic [PIXEL_BIT-1:0]     sram_addr_w_o,
   output logic [VERI_BIT-1:0]      sram_data_w_o,
   output logic                     sram_rd_en_n_o,
   output logic [PIXEL_BIT-1:0]     sram_addr_r_o,
   input  logic [VERI_BIT-1:0]      sram_rd_data_i
);

   typedef enum logic [1:0] {
      ST_BOSTA   = 2'd0,
      ST_SAHIP   = 2'd1,
      ST_TEMIZLE = 2'd2
   } state_t;

   localparam logic [PIXEL_BIT-1:0] c_cnt_last = '1;
   localparam logic [PIXEL_BIT-1:0] c_cnt_one  = {{(PIXEL_BIT-1){1'b0}}, 1'b1};

   state_t                r_state;
   logic [1:0]            r_son;
   logic                  r_pend;
   logic [PIXEL_BIT-1:0]  r_cnt;
   logic [2:0]            r_izin;
   logic [2:0]            r_rdv;
   logic                  r_bitti;

   // last non-stalled SRAM command, replayed while stalled
   logic                  r_wr_n_q;
   logic                  r_rd_n_q;
   logic [PIXEL_BIT-1:0]  r_aw_q;
   logic [PIXEL_BIT-1:0]  r_ar_q;
   logic [VERI_BIT-1:0]   r_dw_q;

   logic                  w_own_req;
   logic                  w_own_wr;
   logic                  w_own_rd;
   logic [PIXEL_BIT-1:0]  w_own_aw;
   logic [PIXEL_BIT-1:0]  w_own_ar;
   logic [VERI_BIT-1:0]   w_own_dw;
   logic [1:0]            w_pick;
   logic [2:0]            w_pick_oh;
   logic                  w_wr_n;
   logic                  w_rd_n;
   logic [PIXEL_BIT-1:0]  w_aw;
   logic [PIXEL_BIT-1:0]  w_ar;
   logic [VERI_BIT-1:0]   w_dw;

   // select the current owner's request and command slices
   always_comb begin
      case (r_son)
         2'd0: begin
            w_own_req = istek_i[0];
            w_own_wr  = wr_en_i[0];
            w_own_rd  = rd_en_i[0];
            w_own_aw  = addr_w_i[0*PIXEL_BIT +: PIXEL_BIT];
            w_own_ar  = addr_r_i[0*PIXEL_BIT +: PIXEL_BIT];
            w_own_dw  = data_w_i[0*VERI_BIT +: VERI_BIT];
         end
         2'd1: begin
            w_own_req = istek_i[1];
            w_own_wr  = wr_en_i[1];
            w_own_rd  = rd_en_i[1];
            w_own_aw  = addr_w_i[1*PIXEL_BIT +: PIXEL_BIT];
            w_own_ar  = addr_r_i[1*PIXEL_BIT +: PIXEL_BIT];
            w_own_dw  = data_w_i[1*VERI_BIT +: VERI_BIT];
         end
         default: begin
            w_own_req = istek_i[2];
            w_own_wr  = wr_en_i[2];
            w_own_rd  = rd_en_i[2];
            w_own_aw  = addr_w_i[2*PIXEL_BIT +: PIXEL_BIT];
            w_own_ar  = addr_r_i[2*PIXEL_BIT +: PIXEL_BIT];
            w_own_dw  = data_w_i[2*VERI_BIT +: VERI_BIT];
         end
      endcase
   end

   // round-robin pick: scan starting just after the previous owner
   always_comb begin
      case (r_son)
         2'd0:    w_pick = istek_i[1] ? 2'd1 : (istek_i[2] ? 2'd2 : 2'd0);
         2'd1:    w_pick = istek_i[2] ? 2'd2 : (istek_i[0] ? 2'd0 : 2'd1);
         default: w_pick = istek_i[0] ? 2'd0 : (istek_i[1] ? 2'd1 : 2'd2);
      endcase
      w_pick_oh = 3'b001 << w_pick;
   end

   // SRAM command for the current state; idle in BOSTA
   always_comb begin
      w_wr_n = 1'b1;
      w_rd_n = 1'b1;
      w_aw   = '0;
      w_ar   = '0;
      w_dw   = '0;
      case (r_state)
         ST_SAHIP: begin
            w_wr_n = ~w_own_wr;
            w_rd_n = ~w_own_rd;
            w_aw   = w_own_aw;
            w_ar   = w_own_ar;
            w_dw   = w_own_dw;
         end
         ST_TEMIZLE: begin
            w_wr_n = 1'b0;
            w_aw   = r_cnt;
         end
         default: ;
      endcase
   end

   // arbiter / clear-sweep FSM with registered grant, valid and done outputs
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state  <= ST_BOSTA;
         r_son    <= 2'd2;
         r_pend   <= 1'b0;
         r_cnt    <= '0;
         r_izin   <= 3'b000;
         r_rdv    <= 3'b000;
         r_bitti  <= 1'b0;
         r_wr_n_q <= 1'b1;
         r_rd_n_q <= 1'b1;
         r_aw_q   <= '0;
         r_ar_q   <= '0;
         r_dw_q   <= '0;
      end else begin
         r_bitti <= 1'b0;
         if (!stal_i) begin
            r_wr_n_q <= w_wr_n;
            r_rd_n_q <= w_rd_n;
            r_aw_q   <= w_aw;
            r_ar_q   <= w_ar;
            r_dw_q   <= w_dw;
            r_rdv    <= (r_state == ST_SAHIP && w_own_rd) ? r_izin : 3'b000;
            case (r_state)
               ST_BOSTA: begin
                  if (r_pend) begin
                     r_state <= ST_TEMIZLE;
                     r_cnt   <= '0;
                     r_pend  <= 1'b0;
                  end else if (|istek_i) begin
                     r_izin  <= w_pick_oh;
                     r_son   <= w_pick;
                     r_state <= ST_SAHIP;
                  end
               end
               ST_SAHIP: begin
                  if (!w_own_req) begin
                     r_izin  <= 3'b000;
                     r_state <= ST_BOSTA;
                  end
               end
               ST_TEMIZLE: begin
                  r_cnt <= r_cnt + c_cnt_one;
                  if (r_cnt == c_cnt_last) begin
                     r_state <= ST_BOSTA;
                     r_bitti <= 1'b1;
                  end
               end
               default: r_state <= ST_BOSTA;
            endcase
            // a new clear request outside the sweep wins over the clear-on-entry above
            if (temizle_i && r_state != ST_TEMIZLE) r_pend <= 1'b1;
         end
      end
   end

   assign izin_o          = r_izin;
   assign rd_gecerli_o    = r_rdv;
   assign temizle_bitti_o = r_bitti;
   assign rd_data_o       = sram_rd_data_i;
   assign sram_wr_en_n_o  = stal_i ? r_wr_n_q : w_wr_n;
   assign sram_rd_en_n_o  = stal_i ? r_rd_n_q : w_rd_n;
   assign sram_addr_w_o   = stal_i ? r_aw_q   : w_aw;
   assign sram_addr_r_o   = stal_i ? r_ar_q   : w_ar;
   assign sram_data_w_o   = stal_i ? r_dw_q   : w_dw;

endmodule
`default_nettype wire

// File: tb/tb_histogram_sram_hakem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_histogram_sram_hakem                                         |
// | Purpose  : Self-checking bench for histogram_sram_hakem with an SRAM model |
// |            and a read-return scoreboard.                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_histogram_sram_hakem;
   localparam int PB = 8;
   localparam int VB = 17;

   logic              clk_i = 1'b0;
   logic              rstn_i;
   logic              stal_i;
   logic              temizle_i;
   logic              temizle_bitti_o;
   logic [2:0]        istek_i;
   logic [2:0]        izin_o;
   logic [2:0]        wr_en_i;
   logic [3*PB-1:0]   addr_w_i;
   logic [3*VB-1:0]   data_w_i;
   logic [2:0]        rd_en_i;
   logic [3*PB-1:0]   addr_r_i;
   logic [VB-1:0]     rd_data_o;
   logic [2:0]        rd_gecerli_o;
   logic              sram_wr_en_n_o;
   logic [PB-1:0]     sram_addr_w_o;
   logic [VB-1:0]     sram_data_w_o;
   logic              sram_rd_en_n_o;
   logic [PB-1:0]     sram_addr_r_o;
   logic [VB-1:0]     sram_rd_data_i;

   always #5 clk_i = ~clk_i;

   histogram_sram_hakem #(.PIXEL_BIT(PB), .VERI_BIT(VB)) dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .stal_i          (stal_i),
      .temizle_i       (temizle_i),
      .temizle_bitti_o (temizle_bitti_o),
      .istek_i         (istek_i),
      .izin_o          (izin_o),
      .wr_en_i         (wr_en_i),
      .addr_w_i        (addr_w_i),
      .data_w_i        (data_w_i),
      .rd_en_i         (rd_en_i),
      .addr_r_i        (addr_r_i),
      .rd_data_o       (rd_data_o),
      .rd_gecerli_o    (rd_gecerli_o),
      .sram_wr_en_n_o  (sram_wr_en_n_o),
      .sram_addr_w_o   (sram_addr_w_o),
      .sram_data_w_o   (sram_data_w_o),
      .sram_rd_en_n_o  (sram_rd_en_n_o),
      .sram_addr_r_o   (sram_addr_r_o),
      .sram_rd_data_i  (sram_rd_data_i)
   );

   // read-first SRAM model, one-cycle read latency
   logic [VB-1:0] mem [0:255];
   logic [VB-1:0] sram_q;
   always @(posedge clk_i) begin
      if (!sram_rd_en_n_o) sram_q <= mem[sram_addr_r_o];
      if (!sram_wr_en_n_o) mem[sram_addr_w_o] <= sram_data_w_o;
   end
   assign sram_rd_data_i = sram_q;

   typedef struct packed {
      logic [2:0]    who;
      logic [VB-1:0] data;
   } exp_t;
   exp_t sb[$];

   int   checks = 0;
   int   errors = 0;
   logic edge_stal = 1'b1;

   // advance one cycle; mid-cycle, retire any fresh read return against the scoreboard
   task automatic tick();
      exp_t e;
      @(negedge clk_i);
      if (rd_gecerli_o !== 3'b000 && !edge_stal) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected rd_gecerli=%b data=%h with nothing expected", rd_gecerli_o, rd_data_o);
         end else begin
            e = sb.pop_front();
            if (rd_gecerli_o !== e.who || rd_data_o !== e.data) begin
               errors++;
               $display("FAIL sb_read got who=%b data=%h expected who=%b data=%h",
                        rd_gecerli_o, rd_data_o, e.who, e.data);
            end
         end
      end
      edge_stal = stal_i;
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_exp(input logic [2:0] who, input logic [VB-1:0] data);
      exp_t e;
      e.who  = who;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic set_req(input int k, input logic wr, input logic [PB-1:0] aw, input logic [VB-1:0] dw,
                          input logic rd, input logic [PB-1:0] ar);
      wr_en_i[k]             = wr;
      addr_w_i[k*PB +: PB]   = aw;
      data_w_i[k*VB +: VB]   = dw;
      rd_en_i[k]             = rd;
      addr_r_i[k*PB +: PB]   = ar;
   endtask

   task automatic clear_cmds();
      wr_en_i  = '0;
      addr_w_i = '0;
      data_w_i = '0;
      rd_en_i  = '0;
      addr_r_i = '0;
   endtask

   task automatic apply_reset();
      rstn_i    = 1'b0;
      stal_i    = 1'b0;
      temizle_i = 1'b0;
      istek_i   = 3'b000;
      clear_cmds();
      sb.delete();
      edge_stal = 1'b1;
      tick();
      tick();
      rstn_i = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      rstn_i = 1'b0;
      tick();
      checks++;
      if (izin_o !== 3'b000 || rd_gecerli_o !== 3'b000 || temizle_bitti_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs izin=%b rdv=%b bitti=%b expected 000 000 0", izin_o, rd_gecerli_o, temizle_bitti_o);
      end
      checks++;
      if (sram_wr_en_n_o !== 1'b1 || sram_rd_en_n_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_sram_en wr_n=%b rd_n=%b expected 1 1", sram_wr_en_n_o, sram_rd_en_n_o);
      end
      checks++;
      if (sram_addr_w_o !== 8'h00 || sram_addr_r_o !== 8'h00 || sram_data_w_o !== 17'h0) begin
         errors++;
         $display("FAIL reset_sram_bus aw=%h ar=%h dw=%h expected 0 0 0", sram_addr_w_o, sram_addr_r_o, sram_data_w_o);
      end
      rstn_i = 1'b1;
      tick();
   endtask

   // T1: full clear sweep, 256 writes of zero then a single done pulse
   task automatic test_clear();
      temizle_i = 1'b1;
      tick();
      temizle_i = 1'b0;
      checks++;
      if (sram_wr_en_n_o !== 1'b1) begin
         errors++;
         $display("FAIL clear_not_yet wr_n=%b expected 1", sram_wr_en_n_o);
      end
      tick();
      for (int i = 0; i < 256; i++) begin
         checks++;
         if (sram_wr_en_n_o !== 1'b0 || sram_addr_w_o !== i[7:0] || sram_data_w_o !== 17'h0 ||
             sram_rd_en_n_o !== 1'b1 || temizle_bitti_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_sweep step=%0d wr_n=%b aw=%h dw=%h rd_n=%b bitti=%b expected 0 %h 0 1 0",
                     i, sram_wr_en_n_o, sram_addr_w_o, sram_data_w_o, sram_rd_en_n_o, temizle_bitti_o, i[7:0]);
         end
         tick();
      end
      checks++;
      if (temizle_bitti_o !== 1'b1 || sram_wr_en_n_o !== 1'b1) begin
         errors++;
         $display("FAIL clear_done bitti=%b wr_n=%b expected 1 1", temizle_bitti_o, sram_wr_en_n_o);
      end
      tick();
      checks++;
      if (temizle_bitti_o !== 1'b0 || sram_wr_en_n_o !== 1'b1 || izin_o !== 3'b000) begin
         errors++;
         $display("FAIL clear_idle bitti=%b wr_n=%b izin=%b expected 0 1 000", temizle_bitti_o, sram_wr_en_n_o, izin_o);
      end
   endtask

   // reset in the middle of a sweep aborts it without a done pulse
   task automatic test_reset_abort();
      logic seen;
      seen = 1'b0;
      temizle_i = 1'b1;
      tick();
      temizle_i = 1'b0;
      repeat (12) tick();
      rstn_i = 1'b0;
      #1;
      checks++;
      if (sram_wr_en_n_o !== 1'b1 || izin_o !== 3'b000) begin
         errors++;
         $display("FAIL abort_immediate wr_n=%b izin=%b expected 1 000", sram_wr_en_n_o, izin_o);
      end
      tick();
      rstn_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (temizle_bitti_o === 1'b1 || sram_wr_en_n_o === 1'b0) seen = 1'b1;
         tick();
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_resume activity_seen=%b expected 0", seen);
      end
   endtask

   // T2: grant latency and release gap
   task automatic test_grant_release();
      apply_reset();
      istek_i = 3'b011;
      tick();
      checks++;
      if (izin_o !== 3'b001) begin
         errors++;
         $display("FAIL grant_first izin=%b expected 001", izin_o);
      end
      repeat (4) tick();
      istek_i = 3'b010;
      tick();
      checks++;
      if (izin_o !== 3'b000) begin
         errors++;
         $display("FAIL release_gap izin=%b expected 000", izin_o);
      end
      tick();
      checks++;
      if (izin_o !== 3'b010) begin
         errors++;
         $display("FAIL grant_next izin=%b expected 010", izin_o);
      end
      istek_i = 3'b000;
      tick();
      tick();
   endtask

   // T3: all three requesting, fair rotation
   task automatic test_round_robin();
      logic [2:0] exp_order [4];
      logic [2:0] g;
      exp_order[0] = 3'b001;
      exp_order[1] = 3'b010;
      exp_order[2] = 3'b100;
      exp_order[3] = 3'b001;
      apply_reset();
      istek_i = 3'b111;
      for (int n = 0; n < 4; n++) begin
         for (int w = 0; w < 10 && izin_o === 3'b000; w++) tick();
         g = izin_o;
         checks++;
         if (g !== exp_order[n]) begin
            errors++;
            $display("FAIL rr_order grant=%0d izin=%b expected %b", n, g, exp_order[n]);
         end
         repeat (3) tick();
         istek_i = 3'b111 & ~g;
         tick();
         istek_i = 3'b111;
      end
      istek_i = 3'b000;
      repeat (3) tick();
   endtask

   // T4: only the owner's command reaches the SRAM; read-first on same-address collision
   task automatic test_owner_mux();
      apply_reset();
      istek_i = 3'b011;
      tick();
      set_req(0, 1'b1, 8'h20, 17'h7, 1'b1, 8'h20);
      set_req(1, 1'b1, 8'h10, 17'h1FFFF, 1'b0, 8'h00);
      push_exp(3'b001, 17'h0);
      #1;
      checks++;
      if (sram_wr_en_n_o !== 1'b0 || sram_addr_w_o !== 8'h20 || sram_data_w_o !== 17'h7) begin
         errors++;
         $display("FAIL owner_write wr_n=%b aw=%h dw=%h expected 0 20 00007", sram_wr_en_n_o, sram_addr_w_o, sram_data_w_o);
      end
      tick();
      set_req(0, 1'b0, 8'h00, 17'h0, 1'b1, 8'h20);
      set_req(1, 1'b0, 8'h00, 17'h0, 1'b0, 8'h00);
      push_exp(3'b001, 17'h7);
      tick();
      set_req(0, 1'b0, 8'h00, 17'h0, 1'b1, 8'h10);
      push_exp(3'b001, 17'h0);
      tick();
      clear_cmds();
      istek_i = 3'b000;
      tick();
      tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL owner_reads_pending left=%0d expected 0", sb.size());
      end
   endtask

   // T5: read return held through a 3-cycle stall with the command replayed
   task automatic test_read_stall();
      apply_reset();
      istek_i = 3'b100;
      tick();
      checks++;
      if (izin_o !== 3'b100) begin
         errors++;
         $display("FAIL oku_grant izin=%b expected 100", izin_o);
      end
      set_req(2, 1'b1, 8'h05, 17'h1ABCD, 1'b0, 8'h00);
      tick();
      set_req(2, 1'b0, 8'h00, 17'h0, 1'b1, 8'h05);
      push_exp(3'b100, 17'h1ABCD);
      tick();
      stal_i = 1'b1;
      set_req(2, 1'b0, 8'h00, 17'h0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (rd_gecerli_o !== 3'b100 || rd_data_o !== 17'h1ABCD || sram_addr_r_o !== 8'h05 || sram_rd_en_n_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d rdv=%b data=%h ar=%h rd_n=%b expected 100 1abcd 05 0",
                     i, rd_gecerli_o, rd_data_o, sram_addr_r_o, sram_rd_en_n_o);
         end
         tick();
      end
      stal_i = 1'b0;
      istek_i = 3'b000;
      tick();
      tick();
      checks++;
      if (rd_gecerli_o !== 3'b000 || sb.size() != 0) begin
         errors++;
         $display("FAIL stall_after rdv=%b left=%0d expected 000 0", rd_gecerli_o, sb.size());
      end
   endtask

   // T6: clear requested during a burst is served before the waiting requester
   task automatic test_clear_pending();
      int writes;
      apply_reset();
      writes = 0;
      istek_i = 3'b001;
      tick();
      istek_i = 3'b011;
      temizle_i = 1'b1;
      tick();
      temizle_i = 1'b0;
      istek_i = 3'b010;
      tick();
      checks++;
      if (izin_o !== 3'b000 || sram_wr_en_n_o !== 1'b1) begin
         errors++;
         $display("FAIL pend_idle izin=%b wr_n=%b expected 000 1", izin_o, sram_wr_en_n_o);
      end
      tick();
      for (int i = 0; i < 256; i++) begin
         if (sram_wr_en_n_o === 1'b0 && sram_addr_w_o === i[7:0] && izin_o === 3'b000) writes++;
         tick();
      end
      checks++;
      if (writes != 256) begin
         errors++;
         $display("FAIL pend_sweep writes=%0d expected 256", writes);
      end
      checks++;
      if (temizle_bitti_o !== 1'b1) begin
         errors++;
         $display("FAIL pend_done bitti=%b expected 1", temizle_bitti_o);
      end
      tick();
      checks++;
      if (izin_o !== 3'b010) begin
         errors++;
         $display("FAIL pend_then_grant izin=%b expected 010", izin_o);
      end
      istek_i = 3'b000;
      tick();
      tick();
   endtask

   initial begin
      rstn_i    = 1'b0;
      stal_i    = 1'b0;
      temizle_i = 1'b0;
      istek_i   = 3'b000;
      clear_cmds();
      test_reset();
      test_clear();
      test_reset_abort();
      test_grant_release();
      test_round_robin();
      test_owner_mux();
      test_read_stall();
      test_clear_pending();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
